// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
package mul_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int STEPS     = WIDTH_DEF / 2;
  localparam int STEP_W    = $clog2(STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth partial-product selector: maps a 3-bit multiplier window to
// digit*a in {-2a,-a,0,+a,+2a}, sign-extended to WIDTH+2 bits.
module booth_r4_sel
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH+1:0] pp
);

  logic [WIDTH+1:0] a_ext;
  logic [WIDTH+1:0] a_x2;

  assign a_ext = {{2{a[WIDTH-1]}}, a};
  assign a_x2  = {a[WIDTH-1], a, 1'b0};

  always_comb begin
    pp = '0;
    unique case (sel)
      3'b001, 3'b010: pp = a_ext;
      3'b011:         pp = a_x2;
      3'b100:         pp = -a_x2;
      3'b101, 3'b110: pp = -a_ext;
      default:        pp = '0;
    endcase
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Iterative signed WIDTH x WIDTH multiplier, two multiplier bits per cycle.
// Optional early exit once the remaining Booth digits are all zero: ALU_MUL_SEQ_EARLY_EXIT_EN.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one Booth step per cycle, busy=1
//   DONE  | result on hi/lo, one-cycle done pulse; start here begins a new op
module alu_mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int ACC_W = 2 * WIDTH + 2;
  localparam int IDX_W = $clog2(WIDTH + 1);

  mul_state_t state_q, state_d;

  logic [WIDTH-1:0]        a_q;
  logic [WIDTH-1:0]        b_q;
  logic [STEP_W-1:0]       step_q;
  logic signed [ACC_W-1:0] acc_q;

  logic                    accept;
  logic                    advance;
  logic                    finish;
  logic                    last_step;
  logic                    early_ok;

  logic [WIDTH:0]          b_ext;
  logic [IDX_W-1:0]        sel_idx;
  logic [WIDTH+1:0]        pp;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_shift;
  logic signed [ACC_W-1:0] acc_final;

  // b[-1] = 0 is supplied by the appended zero; step i reads b_ext[2i+2:2i]
  assign b_ext   = {b_q, 1'b0};
  assign sel_idx = IDX_W'({step_q, 1'b0});

  booth_r4_sel #(.WIDTH(WIDTH)) u_sel (
    .sel (b_ext[sel_idx +: 3]),
    .a   (a_q),
    .pp  (pp)
  );

  // partial product lands at bit WIDTH; 2*STEPS right shifts bring step 0 down to bit 0
  assign acc_sum   = acc_q + $signed({pp, {WIDTH{1'b0}}});
  assign acc_shift = acc_sum >>> 2;
  assign last_step = (step_q == STEP_W'(STEPS - 1));

`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
  logic signed [WIDTH-1:0] b_tail;
  logic [STEP_W:0]         rem_sh;

  // remaining digits are all zero when b above the next window's low bit is pure sign
  assign b_tail    = $signed(b_q) >>> {step_q, 1'b1};
  assign early_ok  = (b_tail == '0) || (b_tail == '1);
  assign rem_sh    = {STEP_W'(STEPS - 1) - step_q, 1'b0};
  assign acc_final = acc_shift >>> rem_sh;
`else
  assign early_ok  = 1'b0;
  assign acc_final = acc_shift;
`endif

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        advance = 1'b1;
        if (last_step || early_ok) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      a_q    <= '0;
      b_q    <= '0;
      step_q <= '0;
      acc_q  <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      step_q <= '0;
      acc_q  <= '0;
    end else if (advance) begin
      step_q <= step_q + 1'b1;
      if (finish) begin
        acc_q <= acc_final;
        hi    <= acc_final[2*WIDTH-1:WIDTH];
        lo    <= acc_final[WIDTH-1:0];
      end else begin
        acc_q <= acc_shift;
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand width; only 32 is required, and WIDTH SHALL be even.
REQ-002 SHALL have port clock  in  1  meaning the single system clock; all flops SHALL be on its rising edge.
REQ-003 SHALL have port clear_n  in  1  meaning the asynchronous, active-low reset.
REQ-004 SHALL have port start  in  1  meaning the multiply request, sampled each rising edge.
REQ-005 SHALL have port a  in  WIDTH  meaning the signed multiplicand.
REQ-006 SHALL have port b  in  WIDTH  meaning the signed multiplier.
REQ-007 SHALL have port busy  out  1  meaning an operation is in progress.
REQ-008 SHALL have port done  out  1  meaning a one-cycle completion pulse.
REQ-009 SHALL have port hi  out  WIDTH  meaning the upper half of the signed product.
REQ-010 SHALL have port lo  out  WIDTH  meaning the lower half of the signed product.

Function
REQ-011 SHALL compute the full 2*WIDTH-bit two's-complement product {hi,lo} = a*b, iteratively, using radix-4 Booth recoding (2 multiplier bits per step, STEPS = WIDTH/2 = 16).
REQ-012 SHALL implement the FSM states IDLE, RUN and DONE, with these transitions:
- IDLE --start--> RUN
- RUN --last step--> DONE
- DONE --start--> RUN
- DONE --!start--> IDLE
REQ-013 SHALL, at the edge where start=1 in IDLE or DONE, capture a and b into internal registers, clear the accumulator, set step=0 and enter RUN; a and b SHALL NOT need to be held after that edge.
REQ-014 SHALL, at each RUN edge, add digit*a (digit in {-2,-1,0,+1,+2}, taken from b[2i+1], b[2i], b[2i-1] with b[-1]=0) into the accumulator, arithmetic-shift by 2, and increment step.
REQ-015 SHALL, at the edge completing step 15, load hi/lo from the accumulator and enter DONE; latency from the accept edge to the done pulse is 17 edges.
REQ-016 SHALL drive busy=1 exactly while in RUN, and done=1 exactly while in DONE (one cycle).
REQ-017 SHALL hold hi/lo stable from one completion until the next completion; hi/lo SHALL NOT change while in RUN.
REQ-018 SHALL ignore start while in RUN, and in-flight operands SHALL be unaffected.
REQ-019 SHALL, on start asserted in DONE, pulse done for that cycle and begin the new operation (back-to-back throughput of 17 cycles).
REQ-020 SHALL treat the corner cases most-negative x most-negative (0x80000000^2 = 0x40000000_00000000) and most-negative x -1 exactly, with no overflow flag.

Reset
REQ-021 SHALL, while clear_n=0, immediately (asynchronously) force state=IDLE, busy=0, done=0, hi=0, lo=0, step=0 and the accumulator to 0.
REQ-022 SHALL, on reset assertion mid-RUN, abandon the operation, with no done pulse and hi/lo=0.
REQ-023 SHALL, after clear_n deassertion, accept start at the first rising edge.

Configuration
REQ-024 SHALL use the macro ALU_MUL_SEQ_EARLY_EXIT_EN to select early-exit behaviour.
- Defined: after completing step i (i = 1..15), if the captured b[WIDTH-1:2i-1] are all identical, the block SHALL shift the accumulator arithmetically by the remaining 2*(16-i) bits in that same edge, load hi/lo and enter DONE. Latency is then 1+i edges (minimum 2).
- Undefined: no early exit; latency is always 17 edges.
REQ-025 SHALL produce identical hi/lo values in both configurations.

Structure
REQ-026 SHALL take the FSM state enum, the WIDTH default and the STEPS constant from the shared package mul_pkg.
REQ-027 SHALL contain one sub-module, booth_r4_sel, which is purely combinational: it takes 3 multiplier bits and a, and returns the sign-extended partial product (WIDTH+2 bits).
REQ-028 SHALL contain all sequencing (FSM, step counter, operand/accumulator registers) in alu_mul_seq; target size is 150-300 lines of RTL.

Verification
REQ-029 Positive x positive: a=0x000001F9, b=0x000000F0 -> hi=0x00000000, lo=0x0001D970, with done exactly 17 edges after accept (early exit disabled).
REQ-030 Mixed sign and negative x negative:
- a=0x0000008B, b=0xFFFFFF74 -> hi=0xFFFFFFFF, lo=0xFFFFB3FC.
- a=0xFFFFFF10, b=0xFFFFFF7B -> hi=0x00000000, lo=0x00007CB0.
REQ-031 Extreme: a=b=0x80000000 -> hi=0x40000000, lo=0x00000000; and a=0x80000000, b=0xFFFFFFFF -> hi=0x00000000, lo=0x80000000.
REQ-032 Handshake:
- start re-pulsed during RUN is ignored, with the result for the original operands.
- start held high through DONE yields a back-to-back second result 17 edges later; busy is low for exactly the DONE cycle.
REQ-033 Reset: clear_n pulsed low at RUN step 7 -> busy=0, done never pulses, hi=lo=0; a fresh start afterwards completes correctly.
REQ-034 With ALU_MUL_SEQ_EARLY_EXIT_EN defined:
- a=5, b=3 -> lo=0x0000000F, done 3 edges after accept.
- b=0 -> done 2 edges after accept.
- The REQ-029..031 values SHALL be unchanged.
